// File: rtl/label_merge_ctrl_if.sv
// Labeler / label-RAM port bundle for label_merge_ctrl.
// oObj_count exists only when LABEL_STATS_EN is defined.
interface label_merge_ctrl_if #(
  parameter int LABEL_W = 6,
  parameter int ADDR_W  = 17
);
  logic               iResolve;
  logic [LABEL_W-1:0] iMerge_lo;
  logic [LABEL_W-1:0] iMerge_hi;
  logic               iLabel_finish;
  logic [ADDR_W-1:0]  oRd_addr;
  logic               oRd_en;
  logic [LABEL_W-1:0] iRd_data;
  logic [ADDR_W-1:0]  oWr_addr;
  logic [LABEL_W-1:0] oWr_data;
  logic               oWr_en;
  logic               oBusy;
  logic               oDone;
  logic               oOverflow;
`ifdef LABEL_STATS_EN
  logic [LABEL_W-1:0] oObj_count;
`endif

  modport master (
    output iResolve, iMerge_lo, iMerge_hi, iLabel_finish, iRd_data,
    input  oRd_addr, oRd_en, oWr_addr, oWr_data, oWr_en, oBusy, oDone, oOverflow
`ifdef LABEL_STATS_EN
    , input oObj_count
`endif
  );

  modport slave (
    input  iResolve, iMerge_lo, iMerge_hi, iLabel_finish, iRd_data,
    output oRd_addr, oRd_en, oWr_addr, oWr_data, oWr_en, oBusy, oDone, oOverflow
`ifdef LABEL_STATS_EN
    , output oObj_count
`endif
  );
endinterface

// File: rtl/label_merge_ctrl.sv
// Connected-component equivalence resolver and relabel sequencer.
// Optional object counter enabled by LABEL_STATS_EN.
module label_merge_ctrl #(
  parameter int LABEL_W    = 6,
  parameter int NUM_LABELS = 64,
  parameter int MAX_PAIRS  = 64,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int ADDR_W     = 17
) (
  input logic iclk,
  input logic irst_n,
  label_merge_ctrl_if.slave bus
);
  localparam int CNT_W  = $clog2(MAX_PAIRS + 1);
  localparam int IDX_W  = $clog2(MAX_PAIRS);
  localparam int PASS_W = $clog2(NUM_LABELS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_LABELS - 1);

  typedef enum logic [1:0] {COLLECT, RESOLVE, RELABEL, DONE} state_t;

  state_t             state;
  logic [LABEL_W-1:0] eq      [NUM_LABELS];
  logic [LABEL_W-1:0] pair_lo [MAX_PAIRS];
  logic [LABEL_W-1:0] pair_hi [MAX_PAIRS];
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [PASS_W-1:0]  pass;
  logic [LABEL_W-1:0] last_lo, last_hi;
  logic               fin_q, chg;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic               rd_en, wr_en, busy, done, ovf;

  logic               fin_edge, skip, take, store, last_pair, pchg, enter_relabel;
  logic [LABEL_W-1:0] r_lo, r_hi, a, b, m, wr_data;

  assign fin_edge  = bus.iLabel_finish & ~fin_q;
  assign skip      = (bus.iMerge_lo == '0) | (bus.iMerge_hi == '0) |
                     (bus.iMerge_lo == bus.iMerge_hi) |
                     ((bus.iMerge_lo == last_lo) & (bus.iMerge_hi == last_hi));
  assign take      = (state == COLLECT) & bus.iResolve & ~skip;
  assign store     = take & (cnt != CNT_W'(MAX_PAIRS));

  // One relaxation step per cycle on the pair at idx
  assign r_lo      = pair_lo[idx];
  assign r_hi      = pair_hi[idx];
  assign a         = eq[r_lo];
  assign b         = eq[r_hi];
  assign m         = (a < b) ? a : b;
  assign pchg      = (a != m) | (b != m);
  assign last_pair = (CNT_W'(idx) + CNT_W'(1)) == cnt;

  assign enter_relabel =
      ((state == COLLECT) & fin_edge & (cnt == '0) & ~store) |
      ((state == RESOLVE) & last_pair & (~(chg | pchg) | (pass == LAST_PASS)));

  // eq[0] stays 0, so background passes through unchanged
  assign wr_data = wr_en ? eq[bus.iRd_data] : '0;

`ifdef LABEL_STATS_EN
  logic [NUM_LABELS-1:0] seen;
  logic [LABEL_W-1:0]    obj_cnt, obj_out, obj_nxt;
  logic                  new_obj;
  assign new_obj = wr_en & (wr_data != '0) & ~seen[wr_data];
  assign obj_nxt = obj_cnt + LABEL_W'(new_obj);
  assign bus.oObj_count = obj_out;
`endif

  always_ff @(posedge iclk) begin
    if (store) begin
      pair_lo[cnt[IDX_W-1:0]] <= bus.iMerge_lo;
      pair_hi[cnt[IDX_W-1:0]] <= bus.iMerge_hi;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state   <= COLLECT;
      for (int i = 0; i < NUM_LABELS; i++) eq[i] <= LABEL_W'(i);
      cnt     <= '0;
      idx     <= '0;
      pass    <= '0;
      last_lo <= '0;
      last_hi <= '0;
      fin_q   <= 1'b0;
      chg     <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
`ifdef LABEL_STATS_EN
      seen    <= '0;
      obj_cnt <= '0;
      obj_out <= '0;
`endif
    end else begin
      fin_q <= bus.iLabel_finish;
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        COLLECT: begin
          if (store) begin
            cnt     <= cnt + CNT_W'(1);
            last_lo <= bus.iMerge_lo;
            last_hi <= bus.iMerge_hi;
          end else if (take) begin
            ovf <= 1'b1;
          end
          if (fin_edge) begin
            state <= RESOLVE;
            busy  <= 1'b1;
            idx   <= '0;
            pass  <= '0;
            chg   <= 1'b0;
          end
        end
        RESOLVE: begin
          eq[r_lo] <= m;
          eq[r_hi] <= m;
          if (last_pair) begin
            idx  <= '0;
            chg  <= 1'b0;
            pass <= pass + PASS_W'(1);
            if ((chg | pchg) && pass == LAST_PASS) ovf <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
            chg <= chg | pchg;
          end
        end
        RELABEL: begin
          wr_en   <= rd_en;
          wr_addr <= rd_addr;
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) rd_en <= 1'b0;
            else                      rd_addr <= rd_addr + ADDR_W'(1);
          end
`ifdef LABEL_STATS_EN
          if (wr_en) begin
            obj_cnt <= obj_nxt;
            if (wr_data != '0) seen[wr_data] <= 1'b1;
          end
`endif
          if (wr_en && wr_addr == LAST_ADDR) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef LABEL_STATS_EN
            obj_out <= obj_nxt;
`endif
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_LABELS; i++) eq[i] <= LABEL_W'(i);
          cnt     <= '0;
          ovf     <= 1'b0;
          last_lo <= '0;
          last_hi <= '0;
          state   <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
      if (enter_relabel) begin
        state   <= RELABEL;
        busy    <= 1'b1;
        rd_en   <= 1'b1;
        rd_addr <= '0;
`ifdef LABEL_STATS_EN
        seen    <= '0;
        obj_cnt <= '0;
`endif
      end
    end
  end

  assign bus.oRd_addr  = rd_addr;
  assign bus.oRd_en    = rd_en;
  assign bus.oWr_addr  = wr_addr;
  assign bus.oWr_data  = wr_data;
  assign bus.oWr_en    = wr_en;
  assign bus.oBusy     = busy;
  assign bus.oDone     = done;
  assign bus.oOverflow = ovf;
endmodule
